// File: rtl/row_fetch_arbiter.sv
// Shares one row-RAM read port between the X and Y row-update channels, round-robin by default.
// Define ROWFETCH_FIXED_PRIO_EN to make X win every tie (Y may starve under sustained X traffic).
module row_fetch_arbiter #(
  parameter int RAM_LAT = 1,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reqX,
  input  logic [ADDR_W-1:0] addrX,
  input  logic              reqY,
  input  logic [ADDR_W-1:0] addrY,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] RowX,
  output logic [DATA_W-1:0] RowY,
  output logic              doneX,
  output logic              doneY,
  output logic              busy
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {CH_X, CH_Y} chan_t;

  state_t              state_q, state_d;
  chan_t               grant_q, grant_d;
  chan_t               last_q, last_d;
  chan_t               pick;
  logic                pend_x_q, pend_x_d;
  logic                pend_y_q, pend_y_d;
  logic [ADDR_W-1:0]   pa_x_q, pa_x_d;
  logic [ADDR_W-1:0]   pa_y_q, pa_y_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   row_x_q, row_x_d;
  logic [DATA_W-1:0]   row_y_q, row_y_d;

  // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    pa_x_d     = pa_x_q;
    pa_y_d     = pa_y_q;
    ram_addr_d = ram_addr_q;
    cnt_d      = cnt_q;
    row_x_d    = row_x_q;
    row_y_d    = row_y_q;
    pick       = CH_X;

    if (pend_x_q && pend_y_q) begin
`ifdef ROWFETCH_FIXED_PRIO_EN
      pick = CH_X;
`else
      pick = (last_q == CH_Y) ? CH_X : CH_Y;
`endif
    end else begin
      pick = pend_x_q ? CH_X : CH_Y;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_x_q || pend_y_q) begin
          grant_d    = pick;
          ram_addr_d = (pick == CH_X) ? pa_x_q : pa_y_q;
          if (pick == CH_X) pend_x_d = 1'b0;
          else              pend_y_d = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(RAM_LAT - 1);
        state_d = WAIT;
      end
      // The WAIT cycle that sees cnt==0 is the one whose closing edge carries valid ram_data.
      WAIT: begin
        if (cnt_q == '0) begin
          if (grant_q == CH_X) row_x_d = ram_data;
          else                 row_y_d = ram_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A request arriving while its own slot is being granted re-arms it rather than being lost.
    if (reqX) begin
      pend_x_d = 1'b1;
      pa_x_d   = addrX;
    end
    if (reqY) begin
      pend_y_d = 1'b1;
      pa_y_d   = addrY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clock) begin
    // NOTE: the row registers are reset too, since both rows must read as zero after reset.
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= CH_X;
      last_q     <= CH_Y;
      pend_x_q   <= 1'b0;
      pend_y_q   <= 1'b0;
      pa_x_q     <= '0;
      pa_y_q     <= '0;
      ram_addr_q <= '0;
      cnt_q      <= '0;
      row_x_q    <= '0;
      row_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pa_x_q     <= pa_x_d;
      pa_y_q     <= pa_y_d;
      ram_addr_q <= ram_addr_d;
      cnt_q      <= cnt_d;
      row_x_q    <= row_x_d;
      row_y_q    <= row_y_d;
    end
  end

  assign ram_en   = (state_q == ISSUE);
  assign ram_addr = ram_addr_q;
  assign RowX     = row_x_q;
  assign RowY     = row_y_q;
  assign doneX    = (state_q == DONE) && (grant_q == CH_X);
  assign doneY    = (state_q == DONE) && (grant_q == CH_Y);
  assign busy     = (state_q != IDLE) || pend_x_q || pend_y_q;

endmodule

// File: tb/tb_row_fetch_arbiter.sv
// Bench for row_fetch_arbiter: two instances (RAM_LAT=1 and RAM_LAT=4) share the stimulus and are
// checked every cycle against a timeline model of grants, plus directed scenario checks.
module tb_row_fetch_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 256;
  localparam int LOG_N  = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_x, req_y;
  logic [ADDR_W-1:0] addr_x, addr_y;

  logic              ram_en   [2];
  logic [ADDR_W-1:0] ram_addr [2];
  logic [DATA_W-1:0] ram_data [2];
  logic [DATA_W-1:0] row_x    [2];
  logic [DATA_W-1:0] row_y    [2];
  logic              done_x   [2];
  logic              done_y   [2];
  logic              busy     [2];

  always #5 clock = ~clock;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    row_fetch_arbiter #(
      .RAM_LAT((k == 0) ? 1 : 4),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_dut (
      .clock   (clock),
      .reset   (reset),
      .reqX    (req_x),
      .addrX   (addr_x),
      .reqY    (req_y),
      .addrY   (addr_y),
      .ram_en  (ram_en[k]),
      .ram_addr(ram_addr[k]),
      .ram_data(ram_data[k]),
      .RowX    (row_x[k]),
      .RowY    (row_y[k]),
      .doneX   (done_x[k]),
      .doneY   (done_y[k]),
      .busy    (busy[k])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    for (int i = 0; i < 16; i++) p[i*16 +: 16] = {a, 5'(i)} ^ 16'hA5C3;
    return p;
  endfunction

  // Timeline model: a grant at cycle c means ram_en at c+1, done at c+2+L, arbiter free at c+3+L.
  logic              m_px [2], m_py [2];
  logic [ADDR_W-1:0] m_pax [2], m_pay [2], m_addr [2];
  int                m_issue [2], m_done [2], m_free [2], m_g [2], m_last [2];
  logic [DATA_W-1:0] m_rowx [2], m_rowy [2];

  logic              slot_v [2][8];
  logic [ADDR_W-1:0] slot_a [2][8];

  int                en_cyc  [2][LOG_N];
  logic [ADDR_W-1:0] en_addr [2][LOG_N];
  int                en_n    [2];
  int                dn_cyc  [2][LOG_N];
  int                dn_ch   [2][LOG_N];
  int                dn_n    [2];

  task automatic model_reset(input int k);
    m_px[k]    = 1'b0;
    m_py[k]    = 1'b0;
    m_pax[k]   = '0;
    m_pay[k]   = '0;
    m_addr[k]  = '0;
    m_issue[k] = -100;
    m_done[k]  = -100;
    m_free[k]  = 0;
    m_g[k]     = 0;
    m_last[k]  = 1;
    m_rowx[k]  = '0;
    m_rowy[k]  = '0;
  endtask

  // Advance the model across the edge that closes cycle cyc, using that cycle's inputs.
  task automatic model_update();
    int g;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        model_reset(k);
      end else begin
        if (cyc + 1 == m_done[k]) begin
          if (m_g[k] == 0) m_rowx[k] = pattern(m_addr[k]);
          else             m_rowy[k] = pattern(m_addr[k]);
        end
        if (cyc == m_done[k]) m_last[k] = m_g[k];
        if (cyc >= m_free[k] && (m_px[k] || m_py[k])) begin
          if (m_px[k] && m_py[k]) begin
`ifdef ROWFETCH_FIXED_PRIO_EN
            g = 0;
`else
            g = (m_last[k] == 1) ? 0 : 1;
`endif
          end else begin
            g = m_px[k] ? 0 : 1;
          end
          m_g[k]    = g;
          m_addr[k] = (g == 0) ? m_pax[k] : m_pay[k];
          if (g == 0) m_px[k] = 1'b0;
          else        m_py[k] = 1'b0;
          m_issue[k] = cyc + 1;
          m_done[k]  = cyc + 2 + lat_of(k);
          m_free[k]  = cyc + 3 + lat_of(k);
        end
        if (req_x) begin m_px[k] = 1'b1; m_pax[k] = addr_x; end
        if (req_y) begin m_py[k] = 1'b1; m_pay[k] = addr_y; end
      end
    end
  endtask

  task automatic compare(input int k);
    string p;
    p = (k == 0) ? "lat1" : "lat4";
    check({p, " ram_en"},   ram_en[k],   cyc == m_issue[k]);
    check({p, " ram_addr"}, ram_addr[k], m_addr[k]);
    check({p, " doneX"},    done_x[k],   (cyc == m_done[k]) && (m_g[k] == 0));
    check({p, " doneY"},    done_y[k],   (cyc == m_done[k]) && (m_g[k] == 1));
    check({p, " RowX"},     row_x[k],    m_rowx[k]);
    check({p, " RowY"},     row_y[k],    m_rowy[k]);
    check({p, " busy"},     busy[k],
          ((cyc >= m_issue[k]) && (cyc <= m_done[k])) || m_px[k] || m_py[k]);
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      en_n[k] = 0;
      dn_n[k] = 0;
      for (int i = 0; i < LOG_N; i++) begin
        en_cyc[k][i]  = 0;
        en_addr[k][i] = '0;
        dn_cyc[k][i]  = 0;
        dn_ch[k][i]   = -1;
      end
    end
  endtask

  // One clock: model update at the edge, then RAM model, comparisons and event logging 1ns later.
  task automatic step();
    @(posedge clock);
    model_update();
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      int s;
      s = cyc % 8;
      for (int w = 0; w < 8; w++) ram_data[k][w*32 +: 32] = $urandom();
      if (slot_v[k][s]) ram_data[k] = pattern(slot_a[k][s]);
      slot_v[k][s] = 1'b0;
      if (ram_en[k] === 1'b1) begin
        slot_v[k][(cyc + lat_of(k)) % 8] = 1'b1;
        slot_a[k][(cyc + lat_of(k)) % 8] = ram_addr[k];
        if (en_n[k] < LOG_N) begin
          en_cyc[k][en_n[k]]  = cyc;
          en_addr[k][en_n[k]] = ram_addr[k];
          en_n[k]++;
        end
      end
      if ((done_x[k] === 1'b1 || done_y[k] === 1'b1) && dn_n[k] < LOG_N) begin
        dn_cyc[k][dn_n[k]] = cyc;
        dn_ch[k][dn_n[k]]  = (done_x[k] === 1'b1) ? 0 : 1;
        dn_n[k]++;
      end
      compare(k);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic single_fetch(input logic [ADDR_W-1:0] a);
    int t0;
    clear_logs();
    t0 = cyc;
    req_x = 1'b1; addr_x = a;
    step();
    req_x = 1'b0;
    repeat (10) step();
    for (int k = 0; k < 2; k++) begin
      check("single en count",    en_n[k], 1);
      check("single en cycle",    en_cyc[k][0] - t0, 2);
      check("single en addr",     en_addr[k][0], a);
      check("single done count",  dn_n[k], 1);
      check("single done cycle",  dn_cyc[k][0] - t0, 3 + lat_of(k));
      check("single done chan",   dn_ch[k][0], 0);
      check("single RowX",        row_x[k], pattern(a));
      check("single RowY",        row_y[k], '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset = 1'b1; req_x = 1'b0; req_y = 1'b0; addr_x = '0; addr_y = '0;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      ram_data[k] = '0;
      for (int s = 0; s < 8; s++) begin slot_v[k][s] = 1'b0; slot_a[k][s] = '0; end
    end
    clear_logs();

    // Reset state
    do_reset(3);
    for (int k = 0; k < 2; k++) begin
      check("reset ram_en",   ram_en[k], 0);
      check("reset ram_addr", ram_addr[k], 0);
      check("reset busy",     busy[k], 0);
      check("reset RowX",     row_x[k], 0);
    end
    repeat (2) step();

    // Single fetch of row 0x005
    single_fetch(11'h005);

    // Simultaneous requests from reset
    do_reset(2);
    clear_logs();
    req_x = 1'b1; addr_x = 11'h010; req_y = 1'b1; addr_y = 11'h020;
    step();
    req_x = 1'b0; req_y = 1'b0;
    repeat (16) step();
    for (int k = 0; k < 2; k++) begin
      check("simul en count",  en_n[k], 2);
      check("simul first addr", en_addr[k][0], 11'h010);
      check("simul second addr", en_addr[k][1], 11'h020);
      check("simul en spacing", en_cyc[k][1] - en_cyc[k][0], 3 + lat_of(k));
      check("simul first done", dn_ch[k][0], 0);
      check("simul second done", dn_ch[k][1], 1);
      check("simul done spacing", dn_cyc[k][1] - dn_cyc[k][0], 3 + lat_of(k));
    end

    // Fairness: both channels keep requesting
    do_reset(2);
    clear_logs();
    for (int i = 0; i < 60; i++) begin
      req_x = 1'b1; addr_x = ADDR_W'($urandom());
      req_y = 1'b1; addr_y = ADDR_W'($urandom());
      step();
    end
    req_x = 1'b0; req_y = 1'b0;
    repeat (20) step();
    for (int k = 0; k < 2; k++) begin
      check("fair done count", dn_n[k] >= 6, 1);
      for (int i = 0; i < 6; i++) begin
`ifdef ROWFETCH_FIXED_PRIO_EN
        check("fair grant order", dn_ch[k][i], 0);
`else
        check("fair grant order", dn_ch[k][i], i % 2);
`endif
      end
    end

    // Address overwrite while Y is in flight
    do_reset(2);
    clear_logs();
    req_y = 1'b1; addr_y = 11'h100;
    step();
    req_y = 1'b0;
    step();
    req_x = 1'b1; addr_x = 11'h001;
    step();
    addr_x = 11'h002;
    step();
    req_x = 1'b0;
    repeat (16) step();
    for (int k = 0; k < 2; k++) begin
      int nx;
      nx = 0;
      for (int i = 0; i < dn_n[k]; i++) if (dn_ch[k][i] == 0) nx++;
      check("overwrite en count", en_n[k], 2);
      check("overwrite X addr",   en_addr[k][1], 11'h002);
      check("overwrite doneX count", nx, 1);
      check("overwrite RowX",     row_x[k], pattern(11'h002));
    end

    // Top row address, latency sweep
    do_reset(2);
    clear_logs();
    t0 = cyc;
    req_y = 1'b1; addr_y = 11'h7FF;
    step();
    req_y = 1'b0;
    repeat (12) step();
    for (int k = 0; k < 2; k++) begin
      check("lat addr",       en_addr[k][0], 11'h7FF);
      check("lat done cycle", dn_cyc[k][0] - t0, 3 + lat_of(k));
      check("lat done chan",  dn_ch[k][0], 1);
      check("lat RowY",       row_y[k], pattern(11'h7FF));
    end

    // Reset in WAIT aborts the fetch and the pending Y request
    do_reset(2);
    req_x = 1'b1; addr_x = 11'h0AB;
    step();
    req_x = 1'b0;
    step();
    req_y = 1'b1; addr_y = 11'h055;
    step();
    req_y = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_logs();
    repeat (8) step();
    for (int k = 0; k < 2; k++) begin
      check("abort done count", dn_n[k], 0);
      check("abort en count",   en_n[k], 0);
      check("abort busy",       busy[k], 0);
      check("abort RowX",       row_x[k], 0);
      check("abort RowY",       row_y[k], 0);
    end
    single_fetch(11'h005);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      req_x  = ($urandom_range(0, 3) == 0);
      req_y  = ($urandom_range(0, 3) == 0);
      addr_x = ADDR_W'($urandom());
      addr_y = ADDR_W'($urandom());
      reset  = ($urandom_range(0, 99) == 0);
      step();
    end
    req_x = 1'b0; req_y = 1'b0; reset = 1'b0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
